// File: rtl/ahb_lite_arbiter.sv
//-----------------------------------------------------------------------------
// ahb_lite_arbiter
//
// Round-robin arbiter that shares one AHB-Lite address/data path between up
// to four masters. It tracks the beats of the transfer currently on the bus
// and moves the grant only at legal boundaries. Fixed-length bursts and locked
// sequences are therefore never split.
//
// Parameters
//   NUM_MASTERS    number of requesters (2..4); upper HBUSREQ bits ignored
//   DEFAULT_MASTER master parked on the bus when nobody requests
//
// Ports
//   HCLK       in   bus clock, all state on the rising edge
//   HRESET     in   synchronous, active-high reset
//   HBUSREQ    in   [3:0] per-master bus request
//   HLOCK      in   [3:0] per-master lock request
//   HTRANS     in   [1:0] transfer type of the muxed address phase
//   HBURST     in   [2:0] burst type of the muxed address phase
//   HREADY     in   combined ready from the slave mux
//   HGRANT     out  [3:0] one-hot grant, registered
//   HMASTER    out  [1:0] address-phase owner (address/control mux select)
//   HMASTER_D  out  [1:0] data-phase owner (write-data mux select)
//   HMASTLOCK  out  registered lock indication for the current owner
//-----------------------------------------------------------------------------
`timescale 1ns/1ps

module ahb_lite_arbiter #(
    parameter int NUM_MASTERS    = 4,
    parameter int DEFAULT_MASTER = 0
) (
    input  logic       HCLK,
    input  logic       HRESET,
    input  logic [3:0] HBUSREQ,
    input  logic [3:0] HLOCK,
    input  logic [1:0] HTRANS,
    input  logic [2:0] HBURST,
    input  logic       HREADY,
    output logic [3:0] HGRANT,
    output logic [1:0] HMASTER,
    output logic [1:0] HMASTER_D,
    output logic       HMASTLOCK
);

    // HTRANS encodings
    localparam logic [1:0] TR_IDLE   = 2'b00;
    localparam logic [1:0] TR_BUSY   = 2'b01;
    localparam logic [1:0] TR_NONSEQ = 2'b10;
    localparam logic [1:0] TR_SEQ    = 2'b11;

    // HBURST encodings
    localparam logic [2:0] BR_SINGLE = 3'b000;
    localparam logic [2:0] BR_INCR   = 3'b001;
    localparam logic [2:0] BR_WRAP4  = 3'b010;
    localparam logic [2:0] BR_INCR4  = 3'b011;
    localparam logic [2:0] BR_WRAP8  = 3'b100;
    localparam logic [2:0] BR_INCR8  = 3'b101;
    localparam logic [2:0] BR_WRAP16 = 3'b110;
    localparam logic [2:0] BR_INCR16 = 3'b111;

    localparam logic [1:0] DEF_IDX   = 2'(DEFAULT_MASTER);
    localparam logic [3:0] DEF_GRANT = 4'b0001 << DEF_IDX;
    // Requests from masters that do not exist are masked off.
    localparam logic [3:0] REQ_MASK  = 4'((1 << NUM_MASTERS) - 1);

    //-------------------------------------------------------------------------
    // State
    //-------------------------------------------------------------------------
    logic [3:0] r_grant;
    logic [1:0] r_master;
    logic [1:0] r_master_d;
    logic       r_mastlock;
    logic [3:0] r_cnt;      // beats still to come after the current one
    logic       r_incr;     // current burst is undefined-length INCR

    //-------------------------------------------------------------------------
    // Combinational signals
    //-------------------------------------------------------------------------
    logic [3:0] w_req;
    logic [1:0] w_winner;
    logic [1:0] w_idx;
    logic       w_found;
    logic [3:0] w_grant_nxt;
    logic [3:0] w_cnt_nxt;
    logic       w_incr_nxt;
    logic       w_data_xfer;
    logic       w_boundary;
    logic       w_arb_ok;

    assign w_req       = HBUSREQ & REQ_MASK;
    assign w_data_xfer = (HTRANS == TR_NONSEQ) || (HTRANS == TR_SEQ);

    //-------------------------------------------------------------------------
    // Round-robin winner: search starts just after the current owner and
    // ends on the owner itself, so the owner only keeps the bus when nobody
    // else is asking.
    //-------------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable gets a default before any conditional update,
        // so no path leaves it unassigned and no latch is inferred.
        w_winner = DEF_IDX;
        w_found  = 1'b0;
        w_idx    = r_master;
        for (int i = 1; i <= NUM_MASTERS; i++) begin
            w_idx = 2'((int'(r_master) + i) % NUM_MASTERS);
            if (!w_found && w_req[w_idx]) begin
                w_winner = w_idx;
                w_found  = 1'b1;
            end
        end
    end

    assign w_grant_nxt = 4'b0001 << w_winner;

    //-------------------------------------------------------------------------
    // Beat tracking. BUSY leaves the count alone; SEQ counts down and
    // saturates, so an overlong burst cannot wrap into a bogus boundary.
    //-------------------------------------------------------------------------
    always_comb begin
        w_cnt_nxt  = r_cnt;
        w_incr_nxt = r_incr;
        case (HTRANS)
            TR_IDLE: begin
                w_cnt_nxt  = 4'd0;
                w_incr_nxt = 1'b0;
            end
            TR_BUSY: begin
                w_cnt_nxt  = r_cnt;
                w_incr_nxt = r_incr;
            end
            TR_NONSEQ: begin
                w_incr_nxt = (HBURST == BR_INCR);
                case (HBURST)
                    BR_SINGLE, BR_INCR:  w_cnt_nxt = 4'd0;
                    BR_WRAP4,  BR_INCR4: w_cnt_nxt = 4'd3;
                    BR_WRAP8,  BR_INCR8: w_cnt_nxt = 4'd7;
                    BR_WRAP16, BR_INCR16: w_cnt_nxt = 4'd15;
                endcase
            end
            TR_SEQ: begin
                if (r_cnt != 4'd0) begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
        endcase
    end

    //-------------------------------------------------------------------------
    // Legal re-arbitration boundary. An undefined-length INCR has no natural
    // end, so it is released as soon as its owner stops requesting.
    //-------------------------------------------------------------------------
    always_comb begin
        w_boundary = 1'b0;
        if (HTRANS == TR_IDLE) begin
            w_boundary = 1'b1;
        end else if ((HTRANS == TR_NONSEQ) && (HBURST == BR_SINGLE)) begin
            w_boundary = 1'b1;
        end else if ((HTRANS == TR_SEQ) && (r_cnt == 4'd1) && !r_incr) begin
            w_boundary = 1'b1;
        end else if (r_incr && w_data_xfer && !HBUSREQ[r_master]) begin
            w_boundary = 1'b1;
        end
    end

    // The owner's live lock bit blocks arbitration; dropping it on a boundary
    // releases the bus on that same edge.
    assign w_arb_ok = HREADY && !HLOCK[r_master] && w_boundary;

    //-------------------------------------------------------------------------
    // State register. A low HREADY freezes everything, including the
    // data-phase owner, because the pending data phase has not completed.
    //-------------------------------------------------------------------------
    always_ff @(posedge HCLK) begin
        // NOTE: non-blocking assignments so every register samples the
        // pre-edge values and the update order inside the block is irrelevant.
        if (HRESET) begin
            r_grant    <= DEF_GRANT;
            r_master   <= DEF_IDX;
            r_master_d <= DEF_IDX;
            r_mastlock <= 1'b0;
            r_cnt      <= 4'd0;
            r_incr     <= 1'b0;
        end else if (HREADY) begin
            r_cnt      <= w_cnt_nxt;
            r_incr     <= w_incr_nxt;
            r_mastlock <= HLOCK[r_master];
            if (w_data_xfer) begin
                r_master_d <= r_master;
            end
            if (w_arb_ok) begin
                r_master <= w_winner;
                r_grant  <= w_grant_nxt;
            end
        end
    end

    assign HGRANT    = r_grant;
    assign HMASTER   = r_master;
    assign HMASTER_D = r_master_d;
    assign HMASTLOCK = r_mastlock;

endmodule

// File: tb/tb_ahb_lite_arbiter.sv
//-----------------------------------------------------------------------------
// tb_ahb_lite_arbiter
//
// Self-checking bench for ahb_lite_arbiter. Each scenario task builds a table
// of per-cycle stimulus with the hand-derived outputs expected after that
// edge. Driving a vector pushes its expectation onto a scoreboard queue; the
// task pops it once the DUT has clocked and compares the observed outputs.
//-----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_ahb_lite_arbiter;

    localparam logic [1:0] T_IDLE   = 2'b00;
    localparam logic [1:0] T_BUSY   = 2'b01;
    localparam logic [1:0] T_NONSEQ = 2'b10;
    localparam logic [1:0] T_SEQ    = 2'b11;

    localparam logic [2:0] B_SINGLE = 3'b000;
    localparam logic [2:0] B_INCR   = 3'b001;
    localparam logic [2:0] B_INCR4  = 3'b011;
    localparam logic [2:0] B_WRAP8  = 3'b100;

    typedef struct packed {
        logic       rst;
        logic [3:0] req;
        logic [3:0] lock;
        logic [1:0] trans;
        logic [2:0] burst;
        logic       rdy;
        logic [1:0] em;     // expected HMASTER
        logic [1:0] emd;    // expected HMASTER_D
        logic       el;     // expected HMASTLOCK
    } vec_t;

    typedef struct packed {
        logic [3:0] grant;
        logic [1:0] master;
        logic [1:0] master_d;
        logic       lock;
    } out_t;

    typedef struct {
        string tag;
        out_t  v;
    } sb_item_t;

    logic       HCLK;
    logic       HRESET;
    logic [3:0] HBUSREQ;
    logic [3:0] HLOCK;
    logic [1:0] HTRANS;
    logic [2:0] HBURST;
    logic       HREADY;
    logic [3:0] HGRANT;
    logic [1:0] HMASTER;
    logic [1:0] HMASTER_D;
    logic       HMASTLOCK;

    sb_item_t sb[$];
    int       n_vec = 0;
    int       n_err = 0;

    ahb_lite_arbiter #(
        .NUM_MASTERS    (4),
        .DEFAULT_MASTER (0)
    ) dut (
        .HCLK      (HCLK),
        .HRESET    (HRESET),
        .HBUSREQ   (HBUSREQ),
        .HLOCK     (HLOCK),
        .HTRANS    (HTRANS),
        .HBURST    (HBURST),
        .HREADY    (HREADY),
        .HGRANT    (HGRANT),
        .HMASTER   (HMASTER),
        .HMASTER_D (HMASTER_D),
        .HMASTLOCK (HMASTLOCK)
    );

    initial begin
        HCLK = 1'b0;
        forever #5 HCLK = ~HCLK;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached before the summary");
        $fatal(1, "watchdog expired");
    end

    function automatic vec_t mk(input logic rst, input logic [3:0] req,
                                input logic [3:0] lock, input logic [1:0] trans,
                                input logic [2:0] burst, input logic rdy,
                                input logic [1:0] em, input logic [1:0] emd,
                                input logic el);
        vec_t v;
        v.rst = rst;   v.req = req;     v.lock = lock;
        v.trans = trans; v.burst = burst; v.rdy = rdy;
        v.em = em;     v.emd = emd;     v.el = el;
        return v;
    endfunction

    function automatic out_t observe();
        out_t o;
        o.grant    = HGRANT;
        o.master   = HMASTER;
        o.master_d = HMASTER_D;
        o.lock     = HMASTLOCK;
        return o;
    endfunction

    function automatic string fmt(input out_t o);
        return $sformatf("grant=%b master=%0d master_d=%0d mastlock=%b",
                         o.grant, o.master, o.master_d, o.lock);
    endfunction

    // Drive one cycle of stimulus, queue its expectation, let the edge pass
    // and settle 1 ns so outputs are sampled away from the clock edge.
    task automatic apply(input vec_t v, input string tag);
        sb_item_t it;
        HRESET  = v.rst;
        HBUSREQ = v.req;
        HLOCK   = v.lock;
        HTRANS  = v.trans;
        HBURST  = v.burst;
        HREADY  = v.rdy;
        it.tag        = tag;
        it.v.grant    = 4'b0001 << v.em;
        it.v.master   = v.em;
        it.v.master_d = v.emd;
        it.v.lock     = v.el;
        sb.push_back(it);
        @(posedge HCLK);
        #1;
    endtask

    task automatic test_reset();
        vec_t     v[$];
        sb_item_t e;
        out_t     o;
        v.push_back(mk(1, 4'b0000, 4'b0000, T_IDLE, B_SINGLE, 1, 0, 0, 0));
        v.push_back(mk(1, 4'b0000, 4'b0000, T_IDLE, B_SINGLE, 1, 0, 0, 0));
        for (int k = 0; k < 4; k++)
            v.push_back(mk(0, 4'b0000, 4'b0000, T_IDLE, B_SINGLE, 1, 0, 0, 0));
        foreach (v[i]) begin
            apply(v[i], $sformatf("reset[%0d]", i));
            e = sb.pop_front();
            o = observe();
            n_vec++;
            if (o !== e.v) begin
                n_err++;
                $display("FAIL %s: got %s, want %s", e.tag, fmt(o), fmt(e.v));
            end
        end
        n_vec++;
        if (dut.r_cnt !== 4'd0 || dut.r_incr !== 1'b0) begin
            n_err++;
            $display("FAIL reset_cnt: got cnt=%0d incr=%b, want cnt=0 incr=0",
                     dut.r_cnt, dut.r_incr);
        end
    endtask

    task automatic test_round_robin();
        vec_t     v[$];
        sb_item_t e;
        out_t     o;
        v.push_back(mk(0, 4'b0110, 4'b0000, T_IDLE, B_SINGLE, 1, 1, 0, 0));
        v.push_back(mk(0, 4'b0110, 4'b0000, T_IDLE, B_SINGLE, 1, 2, 0, 0));
        v.push_back(mk(0, 4'b0110, 4'b0000, T_IDLE, B_SINGLE, 1, 1, 0, 0));
        v.push_back(mk(0, 4'b0110, 4'b0000, T_IDLE, B_SINGLE, 1, 2, 0, 0));
        // HREADY low: grant frozen despite a pending competitor
        v.push_back(mk(0, 4'b0110, 4'b0000, T_IDLE, B_SINGLE, 0, 2, 0, 0));
        v.push_back(mk(0, 4'b0110, 4'b0000, T_IDLE, B_SINGLE, 0, 2, 0, 0));
        foreach (v[i]) begin
            apply(v[i], $sformatf("round_robin[%0d]", i));
            e = sb.pop_front();
            o = observe();
            n_vec++;
            if (o !== e.v) begin
                n_err++;
                $display("FAIL %s: got %s, want %s", e.tag, fmt(o), fmt(e.v));
            end
        end
    endtask

    task automatic test_fixed_burst();
        vec_t     v[$];
        sb_item_t e;
        out_t     o;
        v.push_back(mk(0, 4'b0010, 4'b0000, T_IDLE,   B_SINGLE, 1, 1, 0, 0));
        v.push_back(mk(0, 4'b0110, 4'b0000, T_NONSEQ, B_INCR4,  1, 1, 1, 0));
        v.push_back(mk(0, 4'b0110, 4'b0000, T_SEQ,    B_INCR4,  1, 1, 1, 0));
        v.push_back(mk(0, 4'b0110, 4'b0000, T_SEQ,    B_INCR4,  0, 1, 1, 0));
        v.push_back(mk(0, 4'b0110, 4'b0000, T_SEQ,    B_INCR4,  0, 1, 1, 0));
        // owner drops its request mid-burst: ignored until the last beat
        v.push_back(mk(0, 4'b0100, 4'b0000, T_SEQ,    B_INCR4,  1, 1, 1, 0));
        v.push_back(mk(0, 4'b0100, 4'b0000, T_SEQ,    B_INCR4,  1, 2, 1, 0));
        v.push_back(mk(0, 4'b0100, 4'b0000, T_IDLE,   B_SINGLE, 1, 2, 1, 0));
        foreach (v[i]) begin
            apply(v[i], $sformatf("fixed_burst[%0d]", i));
            e = sb.pop_front();
            o = observe();
            n_vec++;
            if (o !== e.v) begin
                n_err++;
                $display("FAIL %s: got %s, want %s", e.tag, fmt(o), fmt(e.v));
            end
        end
    endtask

    task automatic test_incr_release();
        vec_t     v[$];
        sb_item_t e;
        out_t     o;
        v.push_back(mk(0, 4'b0001, 4'b0000, T_IDLE,   B_SINGLE, 1, 0, 1, 0));
        v.push_back(mk(0, 4'b1001, 4'b0000, T_NONSEQ, B_INCR,   1, 0, 0, 0));
        for (int k = 0; k < 4; k++)
            v.push_back(mk(0, 4'b1001, 4'b0000, T_SEQ, B_INCR, 1, 0, 0, 0));
        v.push_back(mk(0, 4'b1000, 4'b0000, T_SEQ,    B_INCR,   1, 3, 0, 0));
        v.push_back(mk(0, 4'b1000, 4'b0000, T_IDLE,   B_SINGLE, 1, 3, 0, 0));
        foreach (v[i]) begin
            apply(v[i], $sformatf("incr_release[%0d]", i));
            e = sb.pop_front();
            o = observe();
            n_vec++;
            if (o !== e.v) begin
                n_err++;
                $display("FAIL %s: got %s, want %s", e.tag, fmt(o), fmt(e.v));
            end
        end
    endtask

    task automatic test_lock();
        vec_t     v[$];
        sb_item_t e;
        out_t     o;
        v.push_back(mk(0, 4'b0100, 4'b0000, T_IDLE, B_SINGLE, 1, 2, 0, 0));
        for (int k = 0; k < 3; k++)
            v.push_back(mk(0, 4'b1111, 4'b0100, T_NONSEQ, B_SINGLE, 1, 2, 2, 1));
        v.push_back(mk(0, 4'b1111, 4'b0000, T_IDLE, B_SINGLE, 1, 3, 2, 0));
        foreach (v[i]) begin
            apply(v[i], $sformatf("lock[%0d]", i));
            e = sb.pop_front();
            o = observe();
            n_vec++;
            if (o !== e.v) begin
                n_err++;
                $display("FAIL %s: got %s, want %s", e.tag, fmt(o), fmt(e.v));
            end
        end
    endtask

    task automatic test_reset_mid_burst();
        vec_t     v[$];
        sb_item_t e;
        out_t     o;
        v.push_back(mk(0, 4'b1000, 4'b0000, T_NONSEQ, B_WRAP8,  1, 3, 3, 0));
        v.push_back(mk(1, 4'b1000, 4'b0000, T_SEQ,    B_WRAP8,  1, 0, 0, 0));
        foreach (v[i]) begin
            apply(v[i], $sformatf("reset_mid_burst[%0d]", i));
            e = sb.pop_front();
            o = observe();
            n_vec++;
            if (o !== e.v) begin
                n_err++;
                $display("FAIL %s: got %s, want %s", e.tag, fmt(o), fmt(e.v));
            end
        end
        n_vec++;
        if (dut.r_cnt !== 4'd0 || dut.r_incr !== 1'b0) begin
            n_err++;
            $display("FAIL reset_mid_burst_cnt: got cnt=%0d incr=%b, want cnt=0 incr=0",
                     dut.r_cnt, dut.r_incr);
        end
        apply(mk(0, 4'b0000, 4'b0000, T_IDLE, B_SINGLE, 1, 0, 0, 0), "reset_mid_burst_park");
        e = sb.pop_front();
        o = observe();
        n_vec++;
        if (o !== e.v) begin
            n_err++;
            $display("FAIL %s: got %s, want %s", e.tag, fmt(o), fmt(e.v));
        end
    endtask

    task automatic test_busy();
        vec_t     v[$];
        sb_item_t e;
        out_t     o;
        v.push_back(mk(0, 4'b1000, 4'b0000, T_IDLE,   B_SINGLE, 1, 3, 0, 0));
        v.push_back(mk(0, 4'b1001, 4'b0000, T_NONSEQ, B_INCR4,  1, 3, 3, 0));
        v.push_back(mk(0, 4'b1001, 4'b0000, T_BUSY,   B_INCR4,  1, 3, 3, 0));
        v.push_back(mk(0, 4'b1001, 4'b0000, T_SEQ,    B_INCR4,  1, 3, 3, 0));
        v.push_back(mk(0, 4'b1001, 4'b0000, T_SEQ,    B_INCR4,  1, 3, 3, 0));
        v.push_back(mk(0, 4'b1001, 4'b0000, T_SEQ,    B_INCR4,  1, 0, 3, 0));
        v.push_back(mk(0, 4'b0000, 4'b0000, T_IDLE,   B_SINGLE, 1, 0, 3, 0));
        foreach (v[i]) begin
            apply(v[i], $sformatf("busy[%0d]", i));
            e = sb.pop_front();
            o = observe();
            n_vec++;
            if (o !== e.v) begin
                n_err++;
                $display("FAIL %s: got %s, want %s", e.tag, fmt(o), fmt(e.v));
            end
        end
    endtask

    task automatic test_back_to_back();
        vec_t     v[$];
        sb_item_t e;
        out_t     o;
        v.push_back(mk(0, 4'b0011, 4'b0000, T_NONSEQ, B_SINGLE, 1, 1, 0, 0));
        v.push_back(mk(0, 4'b0011, 4'b0000, T_NONSEQ, B_SINGLE, 1, 0, 1, 0));
        v.push_back(mk(0, 4'b0011, 4'b0000, T_NONSEQ, B_SINGLE, 1, 1, 0, 0));
        v.push_back(mk(0, 4'b0000, 4'b0000, T_IDLE,   B_SINGLE, 1, 0, 0, 0));
        foreach (v[i]) begin
            apply(v[i], $sformatf("back_to_back[%0d]", i));
            e = sb.pop_front();
            o = observe();
            n_vec++;
            if (o !== e.v) begin
                n_err++;
                $display("FAIL %s: got %s, want %s", e.tag, fmt(o), fmt(e.v));
            end
        end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_fixed_burst();
        test_incr_release();
        test_lock();
        test_reset_mid_burst();
        test_busy();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ahb_lite_arbiter.md
Name: ahb_lite_arbiter

Overview:
- Round-robin bus arbiter that shares one AHB-Lite address/data path between up to four master requesters.
- Sits in front of the shared decoder/mux fabric. Produces one-hot grants, an address-phase owner index (steers the HADDR/HTRANS/control mux) and a data-phase owner index (steers the HWDATA mux).
- Grant changes only at legal transfer boundaries. Fixed-length bursts and locked sequences are never split.

Parameters:
- NUM_MASTERS, 4, number of requesters (2..4); unused upper request bits are ignored.
- DEFAULT_MASTER, 0, master granted when nobody requests (parks the bus).

Ports:
- HCLK  in  1  bus clock; all logic on rising edge.
- HRESET  in  1  synchronous, active-high reset.
- HBUSREQ  in  4  per-master bus request.
- HLOCK  in  4  per-master lock request; while owner's bit is high, no re-arbitration.
- HTRANS  in  2  transfer type of the current (muxed) address phase.
- HBURST  in  3  burst type of the current address phase.
- HREADY  in  1  combined ready from the slave mux.
- HGRANT  out  4  one-hot grant, registered.
- HMASTER  out  2  index of address-phase owner, registered.
- HMASTER_D  out  2  index of data-phase owner, registered.
- HMASTLOCK  out  1  registered; high while owner holds HLOCK.

Behaviour:
- One clock (HCLK); reset is synchronous and active-high (HRESET).
- Reset values:
  - HGRANT = one-hot(DEFAULT_MASTER); HMASTER = HMASTER_D = DEFAULT_MASTER.
  - HMASTLOCK = 0; beat counter = 0; INCR flag = 0.
- Reset asserted mid-burst aborts the burst. Reset values apply at that edge.
- Beat tracking (updates only on edges with HREADY=1):
  - NONSEQ loads cnt from HBURST: SINGLE=0, INCR4/WRAP4=3, INCR8/WRAP8=7, INCR16/WRAP16=15.
  - NONSEQ with INCR (undefined length) sets the INCR flag and loads cnt=0.
  - SEQ decrements cnt (saturates at 0).
  - BUSY holds cnt and blocks arbitration.
  - IDLE clears cnt and the flag.
- HREADY=0: all state frozen, including grants, cnt and HMASTER_D.
- Arbitration point (arb_ok) is an edge with HREADY=1 and HLOCK[HMASTER]=0 and one of:
  - HTRANS=IDLE.
  - HTRANS=NONSEQ and HBURST=SINGLE.
  - HTRANS=SEQ, cnt==1, INCR flag clear (last beat of a fixed burst).
  - INCR flag set, HTRANS in {NONSEQ, SEQ}, HBUSREQ[HMASTER]=0.
- Winner selection at arb_ok:
  - Search indices HMASTER+1, +2, … wrapping modulo NUM_MASTERS, ending at HMASTER itself.
  - The first index with HBUSREQ=1 wins.
  - No requester: DEFAULT_MASTER.
  - Winner loaded into HMASTER/HGRANT at that edge. New owner drives the address phase from the next cycle.
- Locked sequences:
  - HMASTLOCK <= HLOCK[HMASTER] on every HREADY=1 edge.
  - While HMASTLOCK=1 the grant is held even if other masters request.
  - Release: lock drops and an arb_ok condition holds.
- Data-phase owner: on HREADY=1 edges, HMASTER_D <= HMASTER if HTRANS in {NONSEQ, SEQ}; otherwise HMASTER_D holds.
- Simultaneous events:
  - Owner dropping HBUSREQ mid fixed burst: ignored until the last beat.
  - A new requester arriving on the arb edge itself is eligible.
- Invariants: HGRANT always exactly one-hot; HGRANT == one-hot(HMASTER). Grant latency from request to grant is 1 cycle when the bus is idle.

Test Plan:
- Reset:
  - Stimulus: HRESET=1 for 2 cycles, then 0; HBUSREQ=0000.
  - Required: HGRANT=0001, HMASTER=0, HMASTER_D=0, HMASTLOCK=0; parked on master 0 indefinitely.
- Round-robin:
  - Stimulus: HBUSREQ=0110, HTRANS=IDLE, HREADY=1 every cycle.
  - Required: HMASTER sequence 1,2,1,2; HGRANT alternates 0010/0100.
- Fixed burst not split:
  - Stimulus: master 1 owns; NONSEQ INCR4 then 3 SEQ; HBUSREQ[2]=1 throughout; HREADY low 2 cycles during beat 2.
  - Required: HMASTER stays 1 until the edge accepting beat 4, then becomes 2. HMASTER_D=1 for all 4 data phases. No change during the wait states.
- Undefined INCR release:
  - Stimulus: master 0 NONSEQ INCR plus 5 SEQ beats; drops HBUSREQ[0] on beat 6; HBUSREQ[3]=1.
  - Required: grant moves to 3 at that edge (HGRANT=1000).
- Lock:
  - Stimulus: master 2 HLOCK=1 over 3 SINGLE NONSEQ transfers; HBUSREQ=1111.
  - Required: HMASTLOCK=1 and HMASTER=2 throughout; after lock drops on an IDLE cycle, HMASTER=3.
- Reset mid-burst:
  - Stimulus: HRESET=1 during SEQ beat 2 of WRAP8 owned by master 3.
  - Required: next cycle HGRANT=0001, cnt=0, HMASTER_D=0.
